cntr_wave_gen: RTL and testbench
================================

Name: cntr_wave_gen

Overview:
- Parametrised up/down waveform counter. Successor to the fixed-width free-running triangle counter.
- Adds:
  - programmable lower and upper bounds
  - programmable step size
  - runtime mode select: up-sawtooth, down-sawtooth, triangle, hold
  - turnaround/wrap pulse and direction flag
  - fully synchronous direction logic, with no negedge register
- Drives test-pattern and modulation sources in the HDMI video path, for example ramping colour bars and brightness sweeps.

Parameters:
- WIDTH, 16, bit width of q, lo, hi and sdata.
- STEP_W, 8, bit width of step. Step is zero-extended to WIDTH+1 bits for arithmetic.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- ena  in  1  count enable. Qualifies sclear, sload and counting.
- sclear  in  1  synchronous clear to lo. Takes effect when ena=1.
- sload  in  1  synchronous load of sdata. Takes effect when ena=1.
- sdata  in  WIDTH  load value
- mode  in  2  00 up-saw, 01 down-saw, 10 triangle, 11 hold
- lo  in  WIDTH  lower bound, inclusive
- hi  in  WIDTH  upper bound, inclusive
- step  in  STEP_W  increment/decrement magnitude
- q  out  WIDTH  counter value, registered
- dir  out  1  1 = counting up, 0 = counting down, registered
- wrap  out  1  one-cycle pulse, registered: a wrap or turnaround occurred on the previous edge
- cfg_err  out  1  registered: lo >= hi

Behaviour:
- Reset (rst=1 at posedge): q=0, dir=1, wrap=0, cfg_err=0. rst has the highest priority. rst mid-operation discards any pending turnaround.
- cfg_err is updated every cycle, independent of ena, as (lo >= hi).
- Priority when ena=1: sclear > sload > cfg_err > mode. When ena=0: q and dir hold, wrap=0.
- sclear: q<=lo, dir<=1, wrap<=0.
- sload: q<=sdata. No clamping. dir unchanged. wrap<=0.
- cfg_err=1 (with ena=1, no sclear/sload): q<=lo, wrap<=0, dir unchanged.
- step==0: q holds, wrap<=0, in all modes.
- Arithmetic is done in WIDTH+1 bits, with no modular wraparound: up = q+step, dn = q-step, where dn is negative if q < step.
- mode 00, up-saw:
  - if up > hi: q<=lo, wrap<=1.
  - else: q<=up.
  - dir<=1.
- mode 01, down-saw:
  - if dn < lo (including negative): q<=hi, wrap<=1.
  - else: q<=dn.
  - dir<=0.
- mode 10, triangle:
  - dir=1: if up >= hi, q<=hi, dir<=0, wrap<=1; else q<=up.
  - dir=0: if dn <= lo, q<=lo, dir<=1, wrap<=1; else q<=dn.
  - Endpoints are always hit exactly (clamped). Each endpoint value appears for exactly one enabled cycle per period.
- mode 11, hold: q, dir hold. wrap<=0.
- Out-of-range q (after sload or a bound change) is resolved by the compare rules above:
  - up-saw with q>hi reloads lo on the next step.
  - triangle with q>hi and dir=1 clamps to hi.
- Mode change takes effect on the next enabled edge. dir is preserved when entering triangle.
- wrap is never asserted in the cycle following a reset, sclear, sload, hold, ena=0 or cfg_err cycle.
- Latency: one clock from inputs to q/dir/wrap. All outputs are direct register outputs.

Test Plan:
- Triangle: WIDTH=8, lo=10, hi=20, step=3, ena=1, sclear pulse then mode=10.
  - Required q: 10,13,16,19,20,17,14,11,10,13.
  - wrap=1 in the cycles showing 20 and the second 10.
  - dir falls with q=20 and rises with the second q=10.
- Up-saw overflow: WIDTH=8, lo=0, hi=255, step=16, sload 250, mode=00.
  - Required: next q=0 with wrap=1 (266 > 255 detected in WIDTH+1 bits), then 16, 32.
  - With step=1 from 254: 255, then 0 with wrap.
- Down-saw underflow: lo=5, hi=50, step=10, sload 20, mode=01.
  - Required q: 10, then 50 with wrap=1 (0 < 5), then 40.
  - Also sload 3, step=10: next q=50 (negative dn case).
- Priority/gating:
  - sclear=1, sload=1, ena=1 → q=lo, dir=1.
  - sload=1 with ena=0 → q unchanged.
  - ena toggling mid-triangle → q frozen and wrap=0 while ena=0, sequence resumes exactly.
- Config edges:
  - lo=30, hi=30 → cfg_err=1, q=30 each enabled cycle, wrap=0.
  - step=0 in mode 10 → q constant, no wrap.
  - mode=11 → q and dir frozen.
- Reset mid-operation: triangle counting down at q=14, rst=1 for one cycle → q=0, dir=1, wrap=0 next cycle.
  - Release with lo=10, mode=10: up=3 < hi=20, so q counts up 3,6,9,… (below lo, no clamp, no wrap) until it clamps at hi=20 with wrap=1.

Source files
------------

// File: rtl/cntr_wave_gen.sv
// Programmable up/down waveform counter for test-pattern and modulation sources.
// Generates up-sawtooth, down-sawtooth or triangle ramps between lo and hi,
// or holds, with a programmable step.
//
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   ena           count enable; also qualifies sclear and sload
//   sclear        load lo into q and count up (priority over sload)
//   sload, sdata  load sdata into q, unclamped
//   mode          00 up-saw, 01 down-saw, 10 triangle, 11 hold
//   lo, hi        inclusive bounds
//   step          increment/decrement magnitude
//   q, dir        counter value and direction (1 = up), registered
//   wrap          one-cycle pulse after a wrap or turnaround, registered
//   cfg_err       registered flag for lo >= hi, updated every cycle
module cntr_wave_gen #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STEP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              sclear,
    input  logic              sload,
    input  logic [WIDTH-1:0]  sdata,
    input  logic [1:0]        mode,
    input  logic [WIDTH-1:0]  lo,
    input  logic [WIDTH-1:0]  hi,
    input  logic [STEP_W-1:0] step,
    output logic [WIDTH-1:0]  q,
    output logic              dir,
    output logic              wrap,
    output logic              cfg_err
);

    localparam int unsigned EW = WIDTH + 1;

    localparam logic [1:0] MODE_UP   = 2'b00;
    localparam logic [1:0] MODE_DN   = 2'b01;
    localparam logic [1:0] MODE_TRI  = 2'b10;

    logic [EW-1:0]    up_c;
    logic [EW-1:0]    dn_c;
    logic             up_gt_hi_c;
    logic             up_ge_hi_c;
    logic             dn_lt_lo_c;
    logic             dn_le_lo_c;
    logic             cfg_bad_c;
    logic [WIDTH-1:0] q_nxt_c;
    logic             dir_nxt_c;
    logic             wrap_nxt_c;

    // Extended-width arithmetic: up never wraps modulo 2^WIDTH, and dn's top
    // bit is set exactly when q < step (a negative result).
    always_comb begin
        up_c       = {1'b0, q} + EW'(step);
        dn_c       = {1'b0, q} - EW'(step);
        up_gt_hi_c = up_c >  {1'b0, hi};
        up_ge_hi_c = up_c >= {1'b0, hi};
        dn_lt_lo_c = dn_c[WIDTH] | (dn_c[WIDTH-1:0] <  lo);
        dn_le_lo_c = dn_c[WIDTH] | (dn_c[WIDTH-1:0] <= lo);
        cfg_bad_c  = lo >= hi;
    end

    // Next-state selection in priority order: sclear, sload, bad bounds, mode.
    always_comb begin
        q_nxt_c    = q;
        dir_nxt_c  = dir;
        wrap_nxt_c = 1'b0;
        if (ena) begin
            if (sclear) begin
                q_nxt_c   = lo;
                dir_nxt_c = 1'b1;
            end else if (sload) begin
                q_nxt_c = sdata;
            end else if (cfg_bad_c) begin
                q_nxt_c = lo;
            end else if (step != '0) begin
                case (mode)
                    MODE_UP: begin
                        dir_nxt_c = 1'b1;
                        if (up_gt_hi_c) begin
                            q_nxt_c    = lo;
                            wrap_nxt_c = 1'b1;
                        end else begin
                            q_nxt_c = up_c[WIDTH-1:0];
                        end
                    end
                    MODE_DN: begin
                        dir_nxt_c = 1'b0;
                        if (dn_lt_lo_c) begin
                            q_nxt_c    = hi;
                            wrap_nxt_c = 1'b1;
                        end else begin
                            q_nxt_c = dn_c[WIDTH-1:0];
                        end
                    end
                    MODE_TRI: begin
                        // Clamp to the bound so each endpoint is visited exactly once.
                        if (dir) begin
                            if (up_ge_hi_c) begin
                                q_nxt_c    = hi;
                                dir_nxt_c  = 1'b0;
                                wrap_nxt_c = 1'b1;
                            end else begin
                                q_nxt_c = up_c[WIDTH-1:0];
                            end
                        end else begin
                            if (dn_le_lo_c) begin
                                q_nxt_c    = lo;
                                dir_nxt_c  = 1'b1;
                                wrap_nxt_c = 1'b1;
                            end else begin
                                q_nxt_c = dn_c[WIDTH-1:0];
                            end
                        end
                    end
                    default: begin
                        q_nxt_c   = q;
                        dir_nxt_c = dir;
                    end
                endcase
            end
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            q       <= '0;
            dir     <= 1'b1;
            wrap    <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            q       <= q_nxt_c;
            dir     <= dir_nxt_c;
            wrap    <= wrap_nxt_c;
            cfg_err <= cfg_bad_c;
        end
    end

endmodule

// File: tb/tb_cntr_wave_gen.sv
// Directed bench for cntr_wave_gen (WIDTH=8) with hand-computed expectations.
module tb_cntr_wave_gen;

    localparam int unsigned WIDTH  = 8;
    localparam int unsigned STEP_W = 8;

    logic              clk;
    logic              rst;
    logic              ena;
    logic              sclear;
    logic              sload;
    logic [WIDTH-1:0]  sdata;
    logic [1:0]        mode;
    logic [WIDTH-1:0]  lo;
    logic [WIDTH-1:0]  hi;
    logic [STEP_W-1:0] step;
    logic [WIDTH-1:0]  q;
    logic              dir;
    logic              wrap;
    logic              cfg_err;

    int n_checks;
    int n_fail;

    cntr_wave_gen #(.WIDTH(WIDTH), .STEP_W(STEP_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .sclear  (sclear),
        .sload   (sload),
        .sdata   (sdata),
        .mode    (mode),
        .lo      (lo),
        .hi      (hi),
        .step    (step),
        .q       (q),
        .dir     (dir),
        .wrap    (wrap),
        .cfg_err (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock and settle past the edge before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk3(input string tag, input int eq, input int ed, input int ew);
        check({tag, ".q"},    32'(q),    32'(eq));
        check({tag, ".dir"},  32'(dir),  32'(ed));
        check({tag, ".wrap"}, 32'(wrap), 32'(ew));
    endtask

    int tri_q [9] = '{13, 16, 19, 20, 17, 14, 11, 10, 13};
    int tri_d [9] = '{1, 1, 1, 0, 0, 0, 0, 1, 1};
    int tri_w [9] = '{0, 0, 0, 1, 0, 0, 0, 1, 0};
    int rs_q  [7] = '{3, 6, 9, 12, 15, 18, 20};

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1; ena = 1'b0; sclear = 1'b0; sload = 1'b0; sdata = '0;
        mode = 2'b11; lo = '0; hi = '0; step = '0;
        #2;

        // Reset state (lo >= hi here, but reset forces cfg_err low).
        tick();
        chk3("reset", 0, 1, 0);
        check("reset.cfg_err", 32'(cfg_err), 32'd0);
        rst = 1'b0;

        // Triangle 10..20 step 3 after sclear.
        lo = 8'd10; hi = 8'd20; step = 8'd3; ena = 1'b1; sclear = 1'b1;
        tick();
        chk3("tri_clr", 10, 1, 0);
        check("tri_clr.cfg_err", 32'(cfg_err), 32'd0);
        sclear = 1'b0; mode = 2'b10;
        for (int i = 0; i < 9; i++) begin
            tick();
            chk3($sformatf("tri[%0d]", i), tri_q[i], tri_d[i], tri_w[i]);
        end

        // Enable gating mid-triangle: freeze at 13, resume exactly.
        ena = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk3($sformatf("gate[%0d]", i), 13, 1, 0);
        end
        ena = 1'b1;
        tick(); chk3("resume16", 16, 1, 0);
        tick(); chk3("resume19", 19, 1, 0);
        tick(); chk3("resume20", 20, 0, 1);
        ena = 1'b0;
        tick(); chk3("gate_after_wrap", 20, 0, 0);
        ena = 1'b1;
        tick(); chk3("resume17", 17, 0, 0);
        tick(); chk3("resume14", 14, 0, 0);

        // Reset mid-descent, then count up from 0 below lo without clamping.
        rst = 1'b1;
        tick(); chk3("mid_rst", 0, 1, 0);
        rst = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk3($sformatf("post_rst[%0d]", i), rs_q[i], (i == 6) ? 0 : 1, (i == 6) ? 1 : 0);
        end

        // Up-saw overflow detected in extended width.
        lo = 8'd0; hi = 8'd255; step = 8'd16; mode = 2'b00; sload = 1'b1; sdata = 8'd250;
        tick(); chk3("up_load", 250, 0, 0);
        sload = 1'b0;
        tick(); chk3("up_ovf", 0, 1, 1);
        tick(); chk3("up16", 16, 1, 0);
        tick(); chk3("up32", 32, 1, 0);
        step = 8'd1; sload = 1'b1; sdata = 8'd254;
        tick(); chk3("up_load254", 254, 1, 0);
        sload = 1'b0;
        tick(); chk3("up255", 255, 1, 0);
        tick(); chk3("up_wrap0", 0, 1, 1);

        // Down-saw underflow, including negative dn.
        lo = 8'd5; hi = 8'd50; step = 8'd10; mode = 2'b01; sload = 1'b1; sdata = 8'd20;
        tick(); chk3("dn_load", 20, 1, 0);
        sload = 1'b0;
        tick(); chk3("dn10", 10, 0, 0);
        tick(); chk3("dn_wrap50", 50, 0, 1);
        tick(); chk3("dn40", 40, 0, 0);
        sload = 1'b1; sdata = 8'd3;
        tick(); chk3("dn_load3", 3, 0, 0);
        sload = 1'b0;
        tick(); chk3("dn_neg", 50, 0, 1);

        // sclear beats sload; sload ignored while disabled.
        sclear = 1'b1; sload = 1'b1; sdata = 8'd77;
        tick(); chk3("clr_over_load", 5, 1, 0);
        sclear = 1'b0; ena = 1'b0; sdata = 8'd99;
        tick(); chk3("load_no_ena", 5, 1, 0);
        sload = 1'b0;

        // Degenerate bounds: q pinned to lo, no wrap.
        lo = 8'd30; hi = 8'd30; mode = 2'b10;
        tick();
        check("cfg_err_set", 32'(cfg_err), 32'd1);
        check("cfg_err_noena.q", 32'(q), 32'd5);
        ena = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk3($sformatf("cfg[%0d]", i), 30, 1, 0);
            check($sformatf("cfg[%0d].cfg_err", i), 32'(cfg_err), 32'd1);
        end

        // step=0 in triangle: q constant even though it sits above hi.
        lo = 8'd10; hi = 8'd20; step = 8'd0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk3($sformatf("step0[%0d]", i), 30, 1, 0);
        end
        check("cfg_err_clear", 32'(cfg_err), 32'd0);

        // Hold mode freezes q and dir.
        step = 8'd3; mode = 2'b11;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk3($sformatf("hold[%0d]", i), 30, 1, 0);
        end

        // Triangle with q above hi while counting up clamps to hi.
        mode = 2'b10;
        tick(); chk3("tri_oor_clamp", 20, 0, 1);
        tick(); chk3("tri_oor_next", 17, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
